// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned DATA_BITS          = 8;
  localparam int unsigned STOP_BITS          = 1;
  localparam int unsigned IDX_W              = $clog2(DATA_BITS);
  localparam int unsigned DEFAULT_CLOCK_FREQ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE  = 115_200;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to 1 (line idle).
module uart_bit_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling from a fixed divisor, level-held valid flag.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] uart_out,
  output logic                 uart_out_valid
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);

  logic                 rx_s;
  uart_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] out_d;
  logic                 valid_d;

  uart_bit_sync #(.WIDTH(1)) u_rx_sync (
    .clk (clk),
    .rst (n_rst),
    .d   (serial_in),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      shift_q        <= '0;
      armed_q        <= 1'b0;
      uart_out       <= '0;
      uart_out_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shift_q        <= shift_d;
      armed_q        <= armed_d;
      uart_out       <= out_d;
      uart_out_valid <= valid_d;
    end
  end

  // armed_q blocks start detection until the line has been seen high (after framing error or reset)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    armed_d = armed_q;
    out_d   = uart_out;
    valid_d = uart_out_valid;
    case (state_q)
      IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_DATA_LAST) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = IDLE;
            armed_d = 1'b0;
          end else if (idx_q == IDX_STOP_LAST) begin
            state_d = IDLE;
            out_d   = shift_q;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver against a frame-level reference model.
module tb_uart_receiver;

  localparam int unsigned CLOCK_FREQ = 1_600_000;
  localparam int unsigned BAUD_RATE  = 100_000;
  localparam int unsigned CPB        = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned SOAK_N     = 200;

  logic       clk;
  logic       n_rst;
  logic       serial_in;
  logic [7:0] uart_out;
  logic       uart_out_valid;

  logic [7:0] exp_out;
  logic       exp_valid;
  int         n_checks;
  int         n_errors;

  uart_receiver #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .serial_in      (serial_in),
    .uart_out       (uart_out),
    .uart_out_valid (uart_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bit period on the line, changed on the falling clock edge.
  task automatic drive_bit(input logic v);
    @(negedge clk);
    serial_in = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  // Reference model: any real start clears valid; a good stop publishes the byte.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    serial_in = 1'b0;
    repeat (CPB / 2 - 1) @(negedge clk);
    exp_valid = 1'b0;
    check("valid_clr", 32'(uart_out_valid), 32'(exp_valid));
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (stop_ok) begin
      exp_out   = b;
      exp_valid = 1'b1;
    end
    check("frame_valid", 32'(uart_out_valid), 32'(exp_valid));
    check("frame_data", 32'(uart_out), 32'(exp_out));
  endtask

  initial begin
    logic [7:0] b;
    n_checks  = 0;
    n_errors  = 0;
    serial_in = 1'b1;
    n_rst     = 1'b1;
    exp_out   = 8'h00;
    exp_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    check("reset_data", 32'(uart_out), 32'(exp_out));
    check("reset_valid", 32'(uart_out_valid), 32'(exp_valid));
    idle_bits(2);

    send_frame(8'hA5, 1'b1); idle_bits(1);
    send_frame(8'h00, 1'b1); idle_bits(1);
    send_frame(8'hFF, 1'b1); idle_bits(1);

    for (int n = 0; n < SOAK_N; n++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      idle_bits(1);
    end

    // Short low pulse: enters start detection but fails the mid-bit check.
    @(negedge clk);
    serial_in = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    serial_in = 1'b1;
    exp_valid = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_valid", 32'(uart_out_valid), 32'(exp_valid));
    check("glitch_data", 32'(uart_out), 32'(exp_out));
    send_frame(8'h3C, 1'b1); idle_bits(1);

    send_frame(8'h55, 1'b0); idle_bits(3);
    check("ferr_valid", 32'(uart_out_valid), 32'(exp_valid));
    check("ferr_data", 32'(uart_out), 32'(exp_out));
    send_frame(8'h81, 1'b1); idle_bits(1);

    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle_bits(1);

    // Reset pulse in the middle of data bit 4 of 0xF0.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    @(negedge clk);
    serial_in = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    n_rst = 1'b1;
    #1;
    exp_out   = 8'h00;
    exp_valid = 1'b0;
    check("rst_mid_data", 32'(uart_out), 32'(exp_out));
    check("rst_mid_valid", 32'(uart_out_valid), 32'(exp_valid));
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    idle_bits(3);
    check("post_rst_data", 32'(uart_out), 32'(exp_out));
    check("post_rst_valid", 32'(uart_out_valid), 32'(exp_valid));
    send_frame(8'h99, 1'b1); idle_bits(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
